// File: rtl/lcd_frame_scheduler.sv
// Pixel scheduler for lcdPixelWriter: buffers an sof-tagged upstream stream and
// serves stream, fill or underrun colour per request while staying frame aligned.
module lcd_frame_scheduler #(
  parameter int          H_ACTIVE       = 800,
  parameter int          V_ACTIVE       = 480,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [23:0] FILL_COLOR     = 24'h000000,
  parameter logic [23:0] UNDERRUN_COLOR = 24'hff00ff
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [23:0]                   in_rgb,
  input  logic                          in_sof,
  input  logic                          rgb_request,
  output logic [23:0]                   rgb_out,
  output logic                          buffer_empty,
  output logic                          frame_start,
  output logic                          streaming,
  output logic [15:0]                   underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int IDX_W        = $clog2(FRAME_PIXELS);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, SYNC, STREAM, UNDERRUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [24:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  pix_idx;
  logic [LVL_W-1:0]  level_next;
  logic [23:0]       head_rgb;
  logic [23:0]       rgb_next;
  logic              head_sof;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              count_underrun;
  logic              at_boundary;

  assign in_ready    = fifo_level < LVL_W'(FIFO_DEPTH);
  assign push        = in_valid & in_ready;
  assign fifo_empty  = (fifo_level == '0);
  assign {head_sof, head_rgb} = fifo_mem[rd_ptr];
  assign at_boundary = rgb_request && (pix_idx == '0);

  // Boundary decisions override the per-state behaviour; SYNC and UNDERRUN
  // drain stale non-sof pixels every clock so the next sof reaches the head.
  always_comb begin
    state_next     = state;
    rgb_next       = rgb_out;
    pop            = 1'b0;
    count_underrun = 1'b0;
    if (rgb_request) begin
      if (pix_idx == '0) begin
        if (!enable) begin
          state_next = IDLE;
          rgb_next   = FILL_COLOR;
        end else if (!fifo_empty && head_sof) begin
          state_next = STREAM;
          pop        = 1'b1;
          rgb_next   = head_rgb;
        end else begin
          state_next = SYNC;
          rgb_next   = FILL_COLOR;
        end
      end else begin
        case (state)
          IDLE, SYNC: rgb_next = FILL_COLOR;
          UNDERRUN:   rgb_next = UNDERRUN_COLOR;
          STREAM: begin
            if (fifo_empty) begin
              state_next     = UNDERRUN;
              rgb_next       = UNDERRUN_COLOR;
              count_underrun = 1'b1;
            end else if (!head_sof) begin
              pop      = 1'b1;
              rgb_next = head_rgb;
            end else begin
              state_next = SYNC;
              rgb_next   = FILL_COLOR;
            end
          end
          default: rgb_next = FILL_COLOR;
        endcase
      end
    end
    if ((state == SYNC || state == UNDERRUN) && !fifo_empty && !head_sof)
      pop = 1'b1;
    level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (push && !reset)
      fifo_mem[wr_ptr] <= {in_sof, in_rgb};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      pix_idx        <= '0;
      state          <= IDLE;
      rgb_out        <= FILL_COLOR;
      buffer_empty   <= 1'b1;
      frame_start    <= 1'b0;
      streaming      <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      if (rgb_request)
        pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + IDX_W'(1);
      state        <= state_next;
      rgb_out      <= rgb_next;
      frame_start  <= at_boundary;
      streaming    <= (state_next == STREAM);
      buffer_empty <= (state_next != STREAM) || (level_next == '0);
      if (count_underrun && underrun_count != 16'hffff)
        underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed plus randomized bench for lcd_frame_scheduler on a 4x2 frame with a
// 4-entry FIFO, compared every cycle against a queue-based frame model.
module tb_lcd_frame_scheduler;

  localparam int          H_ACT   = 4;
  localparam int          V_ACT   = 2;
  localparam int          FRAME   = H_ACT * V_ACT;
  localparam int          DEPTH   = 4;
  localparam logic [23:0] FILL    = 24'h000000;
  localparam logic [23:0] UNDER   = 24'hff00ff;
  localparam int          M_IDLE  = 0;
  localparam int          M_SYNC  = 1;
  localparam int          M_STRM  = 2;
  localparam int          M_UNDR  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        in_sof;
  logic        rgb_request;
  logic [23:0] rgb_out;
  logic        buffer_empty;
  logic        frame_start;
  logic        streaming;
  logic [15:0] underrun_count;
  logic [2:0]  fifo_level;

  int compared   = 0;
  int mismatched = 0;

  // Upstream source queue and frame-level reference model state
  logic [24:0] src[$];
  bit          src_on = 1'b1;
  logic [24:0] m_q[$];
  int          m_mode;
  int          m_idx;
  logic [23:0] m_rgb;
  bit          m_fs;
  int          m_cnt;

  lcd_frame_scheduler #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .FIFO_DEPTH(DEPTH),
    .FILL_COLOR(FILL), .UNDERRUN_COLOR(UNDER)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .in_sof(in_sof),
    .rgb_request(rgb_request), .rgb_out(rgb_out), .buffer_empty(buffer_empty),
    .frame_start(frame_start), .streaming(streaming),
    .underrun_count(underrun_count), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One pixel-clock step: drive inputs, advance the model by the frame rules,
  // then compare every registered output one cycle after the edge.
  task automatic applyStimulus(input bit req);
    bit          pushed;
    bit          popped;
    bit          has_head;
    bit          hsof;
    logic [23:0] hrgb;
    int          nm;
    in_valid    = src_on && (src.size() > 0);
    if (in_valid) {in_sof, in_rgb} = src[0];
    else begin
      in_sof = 1'b0;
      in_rgb = 24'($urandom);
    end
    rgb_request = req;
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < DEPTH});
    pushed = 1'b0;
    if (reset) begin
      m_q.delete();
      m_mode = M_IDLE;
      m_idx  = 0;
      m_rgb  = FILL;
      m_fs   = 1'b0;
      m_cnt  = 0;
    end else begin
      has_head = m_q.size() > 0;
      hsof     = has_head && m_q[0][24];
      hrgb     = has_head ? m_q[0][23:0] : 24'h0;
      pushed   = in_valid && (m_q.size() < DEPTH);
      popped   = 1'b0;
      nm       = m_mode;
      m_fs     = req && (m_idx == 0);
      if (req) begin
        if (m_idx == 0) begin
          if (!enable) begin nm = M_IDLE; m_rgb = FILL; end
          else if (hsof) begin nm = M_STRM; popped = 1'b1; m_rgb = hrgb; end
          else begin nm = M_SYNC; m_rgb = FILL; end
        end else if (m_mode == M_STRM) begin
          if (!has_head) begin
            nm = M_UNDR;
            m_rgb = UNDER;
            if (m_cnt < 65535) m_cnt++;
          end else if (!hsof) begin
            popped = 1'b1;
            m_rgb  = hrgb;
          end else begin
            nm = M_SYNC;
            m_rgb = FILL;
          end
        end else begin
          m_rgb = (m_mode == M_UNDR) ? UNDER : FILL;
        end
        m_idx = (m_idx + 1) % FRAME;
      end
      if (!popped && (m_mode == M_SYNC || m_mode == M_UNDR) && has_head && !hsof)
        popped = 1'b1;
      if (popped) void'(m_q.pop_front());
      if (pushed) m_q.push_back({in_sof, in_rgb});
      m_mode = nm;
    end
    @(posedge clock);
    #1;
    if (pushed) void'(src.pop_front());
    checkOutput("rgb_out", {8'd0, rgb_out}, {8'd0, m_rgb});
    checkOutput("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    checkOutput("streaming", {31'd0, streaming}, {31'd0, m_mode == M_STRM});
    checkOutput("buffer_empty", {31'd0, buffer_empty},
                {31'd0, (m_mode != M_STRM) || (m_q.size() == 0)});
    checkOutput("underrun_count", {16'd0, underrun_count}, m_cnt);
    checkOutput("fifo_level", {29'd0, fifo_level}, m_q.size());
  endtask

  task automatic loadFrame(input logic [23:0] base, input int count);
    for (int i = 0; i < count; i++)
      src.push_back({(i == 0), base + 24'(i)});
  endtask

  task automatic runCycles(input int n, input bit req);
    for (int i = 0; i < n; i++) applyStimulus(req);
  endtask

  initial begin
    int gen_pos;
    int gen_len;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_rgb = '0; in_sof = 1'b0;
    rgb_request = 1'b0;
    @(posedge clock); #1;
    applyStimulus(0);
    checkOutput("reset_rgb", {8'd0, rgb_out}, {8'd0, FILL});
    checkOutput("reset_empty", {31'd0, buffer_empty}, 32'd1);
    checkOutput("reset_level", {29'd0, fifo_level}, 32'd0);
    reset = 1'b0;

    $display("[TB] idle fill");
    for (int i = 0; i < 6; i++) src.push_back({1'b0, 24'h000100 + 24'(i)});
    for (int i = 0; i < 6; i++) applyStimulus(i >= 3);
    checkOutput("idle_level", {29'd0, fifo_level}, 32'd4);
    checkOutput("idle_ready", {31'd0, in_ready}, 32'd0);
    src.delete();

    $display("[TB] stream start");
    reset = 1'b1; applyStimulus(0); reset = 1'b0;
    enable = 1'b1;
    loadFrame(24'h000001, 8);
    runCycles(4, 0);
    applyStimulus(1);
    checkOutput("full_pop_level", {29'd0, fifo_level}, 32'd3);
    checkOutput("first_pixel", {8'd0, rgb_out}, 32'h000001);
    runCycles(7, 1);

    $display("[TB] underrun");
    loadFrame(24'h000010, 5);
    runCycles(4, 0);
    runCycles(8, 1);
    checkOutput("underrun_once", {16'd0, underrun_count}, 32'd1);
    loadFrame(24'h000020, 8);
    runCycles(4, 0);
    runCycles(8, 1);

    $display("[TB] misalignment");
    src.push_back({1'b0, 24'h000031});
    src.push_back({1'b0, 24'h000032});
    loadFrame(24'h000040, 8);
    runCycles(4, 0);
    runCycles(16, 1);

    $display("[TB] early sof");
    loadFrame(24'h000050, 5);
    loadFrame(24'h000060, 8);
    runCycles(4, 0);
    runCycles(24, 1);

    $display("[TB] reset mid-frame");
    loadFrame(24'h000070, 8);
    runCycles(4, 0);
    runCycles(3, 1);
    reset = 1'b1; applyStimulus(1); reset = 1'b0;
    checkOutput("midrst_level", {29'd0, fifo_level}, 32'd0);
    checkOutput("midrst_rgb", {8'd0, rgb_out}, {8'd0, FILL});
    checkOutput("midrst_stream", {31'd0, streaming}, 32'd0);
    src.delete();

    $display("[TB] saturation");
    loadFrame(24'h000080, 3);
    runCycles(3, 0);
    force dut.underrun_count = 16'hffff;
    m_cnt = 65535;
    applyStimulus(0);
    release dut.underrun_count;
    runCycles(8, 1);
    checkOutput("saturated", {16'd0, underrun_count}, 32'h0000ffff);

    $display("[TB] random traffic");
    reset = 1'b1; applyStimulus(0); reset = 1'b0;
    gen_pos = 0;
    gen_len = 8;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if (src.size() < 2) begin
        if (gen_pos == 0) gen_len = $urandom_range(5, 10);
        src.push_back({(gen_pos == 0), 24'($urandom)});
        gen_pos = (gen_pos + 1) % gen_len;
      end
      src_on = ($urandom_range(0, 4) != 0);
      reset  = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 9) < 7);
      reset  = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
